dmem_store_buffer: RTL and testbench
====================================

# dmem_store_buffer

Posted-write buffer between the MEM stage and `data_memory`. Accepts stores (sb/sh/sw) into a DEPTH-entry FIFO and drains them one per idle cycle into the memory's write port. Loads get priority on the memory port and read combinationally through the block. A load that hits a pending store's word stalls until that store has drained. The block owns the single `data_memory` port: `Address`, `ReadControl`, `WriteControl` and `WriteData`.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `ADDR_W`, 8, byte-address width (matches `data_memory` Address)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `st_valid`  in  1  store request
- `st_ready`  out  1  store accepted this edge when high
- `st_ctrl`  in  3  funct3: 000 sb, 001 sh, 010 sw
- `st_addr`  in  ADDR_W  store byte address
- `st_data`  in  32  store data, LSB-aligned
- `ld_valid`  in  1  load request
- `ld_ctrl`  in  3  funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
- `ld_addr`  in  ADDR_W  load byte address
- `ld_data`  out  32  load result (from `mem_rdata`)
- `ld_done`  out  1  load serviced this cycle
- `ld_stall`  out  1  load held; requester keeps inputs stable
- `misalign`  out  1  current request misaligned; request dropped
- `drain_req`  in  1  fence: empty the buffer
- `empty`  out  1  no pending stores
- `mem_addr`  out  ADDR_W  to `data_memory` Address
- `mem_wctrl`  out  3  to WriteControl; idle = 3'b011
- `mem_rctrl`  out  3  to ReadControl; idle = 3'b011
- `mem_wdata`  out  32  to WriteData
- `mem_rdata`  in  32  from ReadData
- `stall_cycles`  out  16  saturating load-stall counter (see Configuration)

## Operation
- Entry: {addr, ctrl, data}. Circular FIFO with rd_ptr, wr_ptr (log2 DEPTH) and count (log2 DEPTH + 1). Pointers wrap modulo DEPTH.
- Misalignment rules:
  - sh/lh/lhu with addr[0]=1 is misaligned.
  - sw/lw with addr[1:0]≠0 is misaligned.
  - Misaligned requests: `misalign`=1, store not enqueued, load not issued, `ld_done`=0.
- `st_ready` = (count<DEPTH) & !drain_req. Enqueue on an edge with st_valid & st_ready & !misalign.
- Load hazard: ld_addr[ADDR_W-1:2] equals the word address of any valid entry, or of a store being enqueued in the same cycle.
- Port arbitration, per cycle, in priority order:
  1. ld_valid, !misalign, no hazard, !drain_req: `mem_rctrl`=ld_ctrl, `mem_addr`=ld_addr, `ld_done`=1, `mem_wctrl`=011.
  2. Otherwise, if count>0: drain the head. `mem_wctrl`=head.ctrl, `mem_addr`=head.addr, `mem_wdata`=head.data; rd_ptr advances on the edge.
  3. Otherwise the port is idle: ctrls 011, addr 0, wdata 0.
- `ld_stall` = ld_valid & !misalign & (hazard | drain_req). A stalled load never blocks draining, so forward progress is guaranteed.
- Simultaneous enqueue and drain on one edge: count unchanged. When full, a drain in a cycle does not raise `st_ready` within that same cycle.
- `empty` = (count==0). `drain_req` is held by the requester until `empty`.
- FIFO order preserved: writes to the same word land in program order.

## Timing
- Loads: zero added latency. `ld_data` = `mem_rdata` combinationally in the `ld_done` cycle.
- Stores: presented cycle N, enqueued at edge N. Earliest write to memory at end of cycle N+1 if no load occupies the port.
- Stall: a hazarded load waits at most `count` cycles. Once the last matching entry drains, `ld_done`=1 on the next cycle.
- Reset (sync, takes precedence over all activity): count, pointers, and all entries cleared; pending stores discarded. Outputs after reset, with inputs idle:
  - `st_ready`=1, `empty`=1
  - `ld_done`/`ld_stall`/`misalign`=0
  - `mem_wctrl`=`mem_rctrl`=011, `mem_addr`=0, `mem_wdata`=0, `ld_data`=`mem_rdata`
  - `stall_cycles`=0
- Reset mid-drain: the entry being written in that cycle is still written by memory on the same edge only if `data_memory` is not also in reset. The buffer itself forgets it.

## Configuration
- `STBUF_STALL_STATS_EN` defined: `stall_cycles` increments on every edge where `ld_stall`=1 and saturates at 16'hFFFF. It is cleared by `rst`.
- Not defined: `stall_cycles` is tied to 0 and no counter is synthesised.

## Test plan
- **Store then drain:** sw 0x12345678 @0x10 at cycle 0, no loads → cycle 1 `mem_wctrl`=010, `mem_addr`=0x10; lw @0x10 at cycle 2 → `ld_done`=1, `ld_data`=0x12345678.
- **Fill to full:** DEPTH sw with continuous lw to 0x80 (no hazard) → `st_ready`=0 after 4 stores, loads `ld_done` every cycle. Drop the loads → 4 drain cycles, `empty`=1.
- **Hazard stall:** sb 0xAB @0x21, sh 0xCDEF @0x40, then lbu @0x21 → `ld_stall`=1 for 1 cycle, then `ld_done`=1, `ld_data`=0x000000AB.
- **Misalignment:** sw @0x22 and lh @0x13 → `misalign`=1, nothing enqueued, `mem_rctrl`=011, count unchanged.
- **Fence/reset:** 3 stores, `drain_req`=1 with lw pending → `st_ready`=0, `ld_stall`=1 for 3 cycles, then `empty`=1. Repeat with `rst` after 1 store → `empty`=1 the next cycle, no write issued.
- **Stats (macro on):** 5 stall cycles → `stall_cycles`=5; macro off → stays 0.

Source files
------------

// File: rtl/dmem_store_buffer_if.sv
// Bundle of the store/load request channels and the data_memory port
// around dmem_store_buffer. master = requester + memory side, slave = buffer.
interface dmem_store_buffer_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              st_valid;
    logic              st_ready;
    logic [2:0]        st_ctrl;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;

    logic              ld_valid;
    logic [2:0]        ld_ctrl;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
    logic              ld_done;
    logic              ld_stall;

    logic              misalign;
    logic              drain_req;
    logic              empty;

    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        mem_wctrl;
    logic [2:0]        mem_rctrl;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [15:0]       stall_cycles;

    modport master (
        output st_valid, st_ctrl, st_addr, st_data,
        output ld_valid, ld_ctrl, ld_addr,
        output drain_req, mem_rdata,
        input  st_ready, ld_data, ld_done, ld_stall, misalign, empty,
        input  mem_addr, mem_wctrl, mem_rctrl, mem_wdata, stall_cycles
    );

    modport slave (
        input  st_valid, st_ctrl, st_addr, st_data,
        input  ld_valid, ld_ctrl, ld_addr,
        input  drain_req, mem_rdata,
        output st_ready, ld_data, ld_done, ld_stall, misalign, empty,
        output mem_addr, mem_wctrl, mem_rctrl, mem_wdata, stall_cycles
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer in front of data_memory. Stores queue in a
// circular FIFO and drain one per cycle the port is not used by a load;
// loads bypass combinationally unless they hit a pending store's word.
// Optional load-stall statistics counter: define STBUF_STALL_STATS_EN.
module dmem_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    dmem_store_buffer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [2:0]  CTRL_IDLE = 3'b011;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        ctrl;
        logic [31:0]       data;
    } entry_t;

    entry_t            entries [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              st_mis;
    logic              ld_mis;
    logic              st_ready;
    logic              enq;
    logic              hazard;
    logic              ld_issue;
    logic              deq;
    logic              ld_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        mem_wctrl;
    logic [2:0]        mem_rctrl;
    logic [31:0]       mem_wdata;

    // Access size from funct3[1:0] vs. the low address bits.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            2'b01:   is_misaligned = lsb[0];
            2'b10:   is_misaligned = (lsb != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    // Acceptance, hazard detection and memory-port arbitration.
    always_comb begin
        st_mis    = bus.st_valid & is_misaligned(bus.st_ctrl[1:0], bus.st_addr[1:0]);
        ld_mis    = bus.ld_valid & is_misaligned(bus.ld_ctrl[1:0], bus.ld_addr[1:0]);
        st_ready  = (count < CNT_W'(DEPTH)) & ~bus.drain_req;
        enq       = bus.st_valid & st_ready & ~st_mis;

        // A store entering this cycle counts as pending for the load.
        hazard = enq & (bus.st_addr[ADDR_W-1:2] == bus.ld_addr[ADDR_W-1:2]);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid[i] && (entries[i].addr[ADDR_W-1:2] == bus.ld_addr[ADDR_W-1:2])) begin
                hazard = 1'b1;
            end
        end

        ld_issue = bus.ld_valid & ~ld_mis & ~hazard & ~bus.drain_req;
        ld_stall = bus.ld_valid & ~ld_mis & (hazard | bus.drain_req);
        deq      = ~ld_issue & (count != '0);

        mem_addr  = '0;
        mem_wctrl = CTRL_IDLE;
        mem_rctrl = CTRL_IDLE;
        mem_wdata = '0;
        if (ld_issue) begin
            mem_rctrl = bus.ld_ctrl;
            mem_addr  = bus.ld_addr;
        end else if (deq) begin
            mem_wctrl = entries[rd_ptr].ctrl;
            mem_addr  = entries[rd_ptr].addr;
            mem_wdata = entries[rd_ptr].data;
        end
    end

    // FIFO state: enqueue at the tail, retire the head when it drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
        end else begin
            if (deq) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + PTR_W'(1);
            end
            if (enq) begin
                entries[wr_ptr] <= '{addr: bus.st_addr, ctrl: bus.st_ctrl, data: bus.st_data};
                valid[wr_ptr]   <= 1'b1;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef STBUF_STALL_STATS_EN
    logic [15:0] stall_cnt;

    // Saturating count of cycles a load spent stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (ld_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt;
`else
    assign bus.stall_cycles = 16'd0;
`endif

    assign bus.st_ready  = st_ready;
    assign bus.ld_done   = ld_issue;
    assign bus.ld_stall  = ld_stall;
    assign bus.ld_data   = bus.mem_rdata;
    assign bus.misalign  = st_mis | ld_mis;
    assign bus.empty     = (count == '0);
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wctrl = mem_wctrl;
    assign bus.mem_rctrl = mem_rctrl;
    assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer with a byte-array data_memory model.
module tb_dmem_store_buffer;
    localparam int unsigned ADDR_W = 8;
    localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
    localparam logic [2:0] LH = 3'b001, LW = 3'b010, LBU = 3'b100;
    localparam logic [2:0] IDLE = 3'b011;
`ifdef STBUF_STALL_STATS_EN
    localparam logic [31:0] STALL_EXP = 32'd6;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    dmem_store_buffer_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_store_buffer #(.DEPTH(4), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // data_memory model: byte array, synchronous write, combinational read.
    logic [7:0]  mem [256];
    logic [7:0]  ra;
    logic [31:0] rword;

    always @(posedge clk) begin
        case (bus.mem_wctrl)
            3'b000: mem[bus.mem_addr] <= bus.mem_wdata[7:0];
            3'b001: begin
                mem[bus.mem_addr]          <= bus.mem_wdata[7:0];
                mem[8'(bus.mem_addr + 1)]  <= bus.mem_wdata[15:8];
            end
            3'b010: begin
                mem[bus.mem_addr]          <= bus.mem_wdata[7:0];
                mem[8'(bus.mem_addr + 1)]  <= bus.mem_wdata[15:8];
                mem[8'(bus.mem_addr + 2)]  <= bus.mem_wdata[23:16];
                mem[8'(bus.mem_addr + 3)]  <= bus.mem_wdata[31:24];
            end
            default: ;
        endcase
    end

    always_comb begin
        ra    = bus.mem_addr;
        rword = {mem[8'(ra + 3)], mem[8'(ra + 2)], mem[8'(ra + 1)], mem[ra]};
        case (bus.mem_rctrl)
            3'b000:  bus.mem_rdata = {{24{rword[7]}}, rword[7:0]};
            3'b001:  bus.mem_rdata = {{16{rword[15]}}, rword[15:0]};
            3'b010:  bus.mem_rdata = rword;
            3'b100:  bus.mem_rdata = {24'd0, rword[7:0]};
            3'b101:  bus.mem_rdata = {16'd0, rword[15:0]};
            default: bus.mem_rdata = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        bus.st_valid  = 1'b0;
        bus.st_ctrl   = 3'b000;
        bus.st_addr   = '0;
        bus.st_data   = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_ctrl   = 3'b000;
        bus.ld_addr   = '0;
        bus.drain_req = 1'b0;
    endtask

    task automatic st(input logic [2:0] c, input logic [7:0] a, input logic [31:0] d);
        bus.st_valid = 1'b1;
        bus.st_ctrl  = c;
        bus.st_addr  = a;
        bus.st_data  = d;
    endtask

    task automatic ld(input logic [2:0] c, input logic [7:0] a);
        bus.ld_valid = 1'b1;
        bus.ld_ctrl  = c;
        bus.ld_addr  = a;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_st_ready", 32'(bus.st_ready), 32'd1);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_ld_done", 32'(bus.ld_done), 32'd0);
        chk("rst_ld_stall", 32'(bus.ld_stall), 32'd0);
        chk("rst_misalign", 32'(bus.misalign), 32'd0);
        chk("rst_wctrl", 32'(bus.mem_wctrl), 32'(IDLE));
        chk("rst_rctrl", 32'(bus.mem_rctrl), 32'(IDLE));
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_ld_data", bus.ld_data, 32'd0);
        chk("rst_stall_cycles", 32'(bus.stall_cycles), 32'd0);

        // Preload 0x80 and check the basic store-then-drain timing.
        st(SW, 8'h80, 32'hCAFEBABE);
        settle();
        chk("pre_enq_wctrl_idle", 32'(bus.mem_wctrl), 32'(IDLE));
        tick();
        idle();
        settle();
        chk("pre_drain_wctrl", 32'(bus.mem_wctrl), 32'(SW));
        chk("pre_drain_addr", 32'(bus.mem_addr), 32'h80);
        tick();

        st(SW, 8'h10, 32'h12345678);
        settle();
        chk("s1_st_ready", 32'(bus.st_ready), 32'd1);
        tick();
        idle();
        settle();
        chk("s1_wctrl", 32'(bus.mem_wctrl), 32'(SW));
        chk("s1_addr", 32'(bus.mem_addr), 32'h10);
        chk("s1_wdata", bus.mem_wdata, 32'h12345678);
        chk("s1_not_empty", 32'(bus.empty), 32'd0);
        tick();
        ld(LW, 8'h10);
        settle();
        chk("s1_ld_done", 32'(bus.ld_done), 32'd1);
        chk("s1_ld_data", bus.ld_data, 32'h12345678);
        chk("s1_rctrl", 32'(bus.mem_rctrl), 32'(LW));
        chk("s1_empty", 32'(bus.empty), 32'd1);
        tick();

        // Fill to full while a non-hazard load holds the port.
        idle();
        ld(LW, 8'h80);
        for (int k = 0; k < 4; k++) begin
            st(SW, 8'(8'h30 + 4 * k), 32'(32'hA0 + k));
            settle();
            chk("fill_st_ready", 32'(bus.st_ready), 32'd1);
            chk("fill_ld_done", 32'(bus.ld_done), 32'd1);
            chk("fill_ld_data", bus.ld_data, 32'hCAFEBABE);
            chk("fill_wctrl_idle", 32'(bus.mem_wctrl), 32'(IDLE));
            tick();
        end
        st(SW, 8'h50, 32'h55);
        settle();
        chk("full_st_ready", 32'(bus.st_ready), 32'd0);
        chk("full_ld_done", 32'(bus.ld_done), 32'd1);
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("drain_wctrl", 32'(bus.mem_wctrl), 32'(SW));
            chk("drain_addr", 32'(bus.mem_addr), 32'(8'h30 + 4 * k));
            chk("drain_wdata", bus.mem_wdata, 32'(32'hA0 + k));
            if (k == 0) chk("drain_full_st_ready", 32'(bus.st_ready), 32'd0);
            tick();
        end
        settle();
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_wctrl_idle", 32'(bus.mem_wctrl), 32'(IDLE));
        ld(LW, 8'h3C);
        settle();
        chk("drain_readback", bus.ld_data, 32'h000000A3);
        tick();

        // Load hitting a pending byte store stalls until it drains.
        idle();
        st(SB, 8'h21, 32'h000000AB);
        settle();
        chk("hz_wctrl_idle", 32'(bus.mem_wctrl), 32'(IDLE));
        tick();
        st(SH, 8'h40, 32'h0000CDEF);
        ld(LBU, 8'h21);
        settle();
        chk("hz_stall", 32'(bus.ld_stall), 32'd1);
        chk("hz_no_done", 32'(bus.ld_done), 32'd0);
        chk("hz_rctrl_idle", 32'(bus.mem_rctrl), 32'(IDLE));
        chk("hz_drain_wctrl", 32'(bus.mem_wctrl), 32'(SB));
        chk("hz_drain_addr", 32'(bus.mem_addr), 32'h21);
        tick();
        bus.st_valid = 1'b0;
        settle();
        chk("hz_done", 32'(bus.ld_done), 32'd1);
        chk("hz_no_stall", 32'(bus.ld_stall), 32'd0);
        chk("hz_ld_data", bus.ld_data, 32'h000000AB);
        chk("hz_rctrl", 32'(bus.mem_rctrl), 32'(LBU));
        chk("hz_sh_waits", 32'(bus.mem_wctrl), 32'(IDLE));
        tick();
        bus.ld_valid = 1'b0;
        settle();
        chk("hz_sh_wctrl", 32'(bus.mem_wctrl), 32'(SH));
        chk("hz_sh_wdata", bus.mem_wdata, 32'h0000CDEF);
        tick();
        ld(LH, 8'h40);
        settle();
        chk("hz_lh_sext", bus.ld_data, 32'hFFFFCDEF);
        tick();

        // Hazard against a store enqueued in the same cycle.
        idle();
        st(SW, 8'h60, 32'h11223344);
        ld(LW, 8'h60);
        settle();
        chk("same_stall", 32'(bus.ld_stall), 32'd1);
        chk("same_no_done", 32'(bus.ld_done), 32'd0);
        chk("same_wctrl_idle", 32'(bus.mem_wctrl), 32'(IDLE));
        tick();
        bus.st_valid = 1'b0;
        settle();
        chk("same_stall2", 32'(bus.ld_stall), 32'd1);
        chk("same_drain_addr", 32'(bus.mem_addr), 32'h60);
        tick();
        settle();
        chk("same_done", 32'(bus.ld_done), 32'd1);
        chk("same_ld_data", bus.ld_data, 32'h11223344);
        tick();

        // Misaligned store and load are dropped.
        idle();
        st(SW, 8'h22, 32'hDEADBEEF);
        settle();
        chk("mis_st_flag", 32'(bus.misalign), 32'd1);
        chk("mis_st_wctrl", 32'(bus.mem_wctrl), 32'(IDLE));
        tick();
        idle();
        settle();
        chk("mis_st_empty", 32'(bus.empty), 32'd1);
        ld(LH, 8'h13);
        settle();
        chk("mis_ld_flag", 32'(bus.misalign), 32'd1);
        chk("mis_ld_done", 32'(bus.ld_done), 32'd0);
        chk("mis_ld_stall", 32'(bus.ld_stall), 32'd0);
        chk("mis_ld_rctrl", 32'(bus.mem_rctrl), 32'(IDLE));
        tick();
        idle();
        settle();
        chk("mis_ld_empty", 32'(bus.empty), 32'd1);

        // Fence with three pending stores and a load waiting.
        ld(LW, 8'h80);
        for (int k = 0; k < 3; k++) begin
            st(SW, 8'(8'h70 + 4 * k), 32'(32'hF0 + k));
            settle();
            chk("fence_fill_done", 32'(bus.ld_done), 32'd1);
            tick();
        end
        bus.st_valid  = 1'b0;
        bus.drain_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("fence_st_ready", 32'(bus.st_ready), 32'd0);
            chk("fence_stall", 32'(bus.ld_stall), 32'd1);
            chk("fence_no_done", 32'(bus.ld_done), 32'd0);
            chk("fence_wctrl", 32'(bus.mem_wctrl), 32'(SW));
            chk("fence_addr", 32'(bus.mem_addr), 32'(8'h70 + 4 * k));
            tick();
        end
        bus.drain_req = 1'b0;
        settle();
        chk("fence_empty", 32'(bus.empty), 32'd1);
        chk("fence_ld_done", 32'(bus.ld_done), 32'd1);
        chk("fence_ld_data", bus.ld_data, 32'hCAFEBABE);
        tick();

        idle();
        settle();
        chk("stall_cycles", 32'(bus.stall_cycles), STALL_EXP);

        // Reset discards a pending store.
        ld(LW, 8'h80);
        st(SW, 8'h90, 32'h99999999);
        settle();
        chk("rstp_wctrl_idle", 32'(bus.mem_wctrl), 32'(IDLE));
        tick();
        bus.st_valid = 1'b0;
        rst = 1'b1;
        settle();
        chk("rstp_pending", 32'(bus.empty), 32'd0);
        tick();
        rst = 1'b0;
        idle();
        settle();
        chk("rstp_empty", 32'(bus.empty), 32'd1);
        chk("rstp_wctrl", 32'(bus.mem_wctrl), 32'(IDLE));
        chk("rstp_addr", 32'(bus.mem_addr), 32'd0);
        chk("rstp_st_ready", 32'(bus.st_ready), 32'd1);
        chk("rstp_stall_cycles", 32'(bus.stall_cycles), 32'd0);
        tick();
        settle();
        chk("rstp_no_write", 32'(bus.mem_wctrl), 32'(IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
